// File: rtl/uart_tx_fifo_if.sv
// Bus-side bundle of the UART transmitter: baud tick, write port, serial line and FIFO status.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             tick;
    logic             i_tx_en;
    logic             i_wr;
    logic [7:0]       i_tx_data;
    logic             o_tx;
    logic             o_busy;
    logic             o_done;
    logic             o_full;
    logic             o_empty;
    logic             o_overflow;
    logic [CNT_W-1:0] o_count;

    // Producer side: issues ticks and bytes, observes line and status.
    modport master (
        output tick, i_tx_en, i_wr, i_tx_data,
        input  o_tx, o_busy, o_done, o_full, o_empty, o_overflow, o_count
    );

    // Transmitter side.
    modport slave (
        input  tick, i_tx_en, i_wr, i_tx_data,
        output o_tx, o_busy, o_done, o_full, o_empty, o_overflow, o_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small TX FIFO, timed by a shared oversample tick.
// Bytes are queued from the bus, popped one at a time into a shift register and
// sent as start bit, 8 data bits LSB first, stop bit. All outputs are registered.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Serialiser state
    state_t            state_r;
    state_t            state_nxt_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [TICK_W-1:0] tick_cnt_nxt_s;
    logic [2:0]        bit_cnt_r;
    logic [2:0]        bit_cnt_nxt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              bit_end_s;

    // Accept a write only when the FIFO is not full as of this cycle; a pop in the
    // same cycle does not make room for the write.
    always_comb begin
        push_s      = 1'b0;
        count_nxt_s = count_r;
        if (bus.i_wr && !full_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Byte storage; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.i_tx_data;
        end
    end

    // FIFO pointers, occupancy, registered full/empty flags and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (bus.i_wr && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    // Frame sequencing: bit timer, shift register and next values of the line outputs.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        tx_nxt_s       = tx_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        pop_s          = 1'b0;
        bit_end_s      = 1'b0;

        // A bit period closes on the tick that completes OVERSAMPLE ticks.
        if (bus.tick && (tick_cnt_r == TICK_W'(OVERSAMPLE - 1))) begin
            bit_end_s = 1'b1;
        end else begin
            bit_end_s = 1'b0;
        end

        // The timer only runs inside a frame; ticks seen in IDLE are ignored.
        if ((state_r != ST_IDLE) && bus.tick) begin
            if (bit_end_s) begin
                tick_cnt_nxt_s = {TICK_W{1'b0}};
            end else begin
                tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_cnt_nxt_s = tick_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                tx_nxt_s   = 1'b1;
                busy_nxt_s = 1'b0;
                if (bus.i_tx_en && !empty_r) begin
                    pop_s          = 1'b1;
                    shift_nxt_s    = mem_r[rd_ptr_r];
                    tick_cnt_nxt_s = {TICK_W{1'b0}};
                    bit_cnt_nxt_s  = 3'd0;
                    state_nxt_s    = ST_START;
                    tx_nxt_s       = 1'b0;
                    busy_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                        tx_nxt_s    = 1'b1;
                    end else begin
                        // Present the next data bit, which becomes shift[0] after the shift.
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        tx_nxt_s      = shift_r[1];
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                    tx_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tx_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Serialiser state register and registered line outputs; reset forces the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TICK_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign bus.o_tx       = tx_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_done     = done_r;
    assign bus.o_full     = full_r;
    assign bus.o_empty    = empty_r;
    assign bus.o_overflow = overflow_r;
    assign bus.o_count    = count_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo. Accepted bytes go into an expected
// queue; a line monitor decodes o_tx as a UART receiver on the same tick and pops
// and compares one byte per frame.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int OS    = 16;

    logic clk = 1'b0;
    logic rst;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    int         tick_mode = 1;
    int         frames_done = 0;
    logic       in_frame = 1'b0;
    logic       expect_b2b = 1'b0;
    int         gap_violations = 0;
    logic [9:0] last_bits = 10'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tick generator: every 4th clock, or random with ~7/8 density.
    initial begin : tick_gen
        int ph;
        ph = 0;
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            case (tick_mode)
                1:       bus.tick = (ph == 0);
                2:       bus.tick = ($urandom_range(0, 7) != 0);
                default: bus.tick = 1'b0;
            endcase
        end
    end

    // Line monitor: a receiver that counts ticks per bit and compares each frame
    // against the head of the expected queue.
    initial begin : monitor
        logic       prev_tx;
        int         tcnt;
        int         since_done;
        logic [9:0] rx_bits;
        logic [7:0] exp_b;
        logic       incons;
        logic       ctrl_bad;
        prev_tx = 1'b1; tcnt = 0; since_done = 100; rx_bits = 10'd0;
        exp_b = 8'd0; incons = 1'b0; ctrl_bad = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_frame   = 1'b0;
                since_done = 100;
            end else if (!in_frame) begin
                check("idle_done", 32'(bus.o_done), 32'd0);
                if (bus.o_tx == 1'b0) begin
                    check("frame_expected", 32'(model_q.size() != 0), 32'd1);
                    if (model_q.size() != 0) exp_b = model_q.pop_front();
                    else exp_b = 8'h00;
                    if (expect_b2b && since_done > 0) gap_violations++;
                    in_frame = 1'b1; tcnt = 0; rx_bits = 10'd0;
                    incons = 1'b0; ctrl_bad = 1'b0;
                end
                since_done++;
            end else begin
                if (bus.tick == 1'b1) begin
                    if (tcnt % OS == 0) rx_bits[tcnt / OS] = prev_tx;
                    else if (rx_bits[tcnt / OS] !== prev_tx) incons = 1'b1;
                    tcnt++;
                end
                if (tcnt == 10 * OS) begin
                    check("frame_bits", 32'(rx_bits), 32'({1'b1, exp_b, 1'b0}));
                    check("bit_stable", 32'(incons), 32'd0);
                    check("frame_ctrl", 32'(ctrl_bad), 32'd0);
                    check("done_pulse", 32'({bus.o_done, bus.o_busy, bus.o_tx}), 32'b101);
                    last_bits   = rx_bits;
                    frames_done++;
                    in_frame    = 1'b0;
                    since_done  = 0;
                end else if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
                    ctrl_bad = 1'b1;
                end
            end
            prev_tx = bus.o_tx;
        end
    end

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_wr      = 1'b1;
        bus.i_tx_data = b;
        if (model_q.size() >= DEPTH) model_ovf = 1'b1;
        else model_q.push_back(b);
    endtask

    task automatic end_wr();
        @(negedge clk);
        bus.i_wr = 1'b0;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(bus.o_count), 32'(model_q.size()));
        check({tag, "_full"},  32'(bus.o_full),  32'(model_q.size() == DEPTH));
        check({tag, "_empty"}, 32'(bus.o_empty), 32'(model_q.size() == 0));
        check({tag, "_ovf"},   32'(bus.o_overflow), 32'(model_ovf));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_tx"},    32'(bus.o_tx),       32'd1);
        check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
        check({tag, "_done"},  32'(bus.o_done),     32'd0);
        check({tag, "_full"},  32'(bus.o_full),     32'd0);
        check({tag, "_empty"}, 32'(bus.o_empty),    32'd1);
        check({tag, "_ovf"},   32'(bus.o_overflow), 32'd0);
        check({tag, "_count"}, 32'(bus.o_count),    32'd0);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(model_q.size() == 0 && !in_frame && bus.o_busy == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic wait_frame(input string name, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !in_frame) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < max_cyc), 32'd1);
    endtask

    initial begin : stimulus
        int         f0;
        int         sent;
        int         guard;
        logic [7:0] b;

        rst           = 1'b1;
        bus.i_tx_en   = 1'b0;
        bus.i_wr      = 1'b0;
        bus.i_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        // Single frame of 0xA5 at one tick per 4 clocks.
        tick_mode   = 1;
        bus.i_tx_en = 1'b1;
        f0 = frames_done;
        put_byte(8'hA5);
        end_wr();
        wait_idle("a5_idle", 2000);
        check("a5_frames", 32'(frames_done - f0), 32'd1);
        check("a5_pattern", 32'(last_bits), 32'b1101001010);

        // Three back-to-back frames with no idle bit period between them.
        f0 = frames_done;
        gap_violations = 0;
        put_byte(8'h00);
        put_byte(8'hFF);
        put_byte(8'h3C);
        end_wr();
        wait_frame("b2b_start", 50);
        expect_b2b = 1'b1;
        wait_idle("b2b_idle", 3000);
        expect_b2b = 1'b0;
        check("b2b_frames", 32'(frames_done - f0), 32'd3);
        check("b2b_gaps", 32'(gap_violations), 32'd0);
        check_status("b2b_end");

        // Fill with transmit disabled, overflow on the fifth write, then drain.
        bus.i_tx_en = 1'b0;
        put_byte(8'h11);
        put_byte(8'h22);
        put_byte(8'h33);
        put_byte(8'h44);
        put_byte(8'h55);
        end_wr();
        check_status("fill");
        check("fill_count4", 32'(bus.o_count), 32'd4);
        check("fill_ovf", 32'(bus.o_overflow), 32'd1);
        f0 = frames_done;
        bus.i_tx_en = 1'b1;
        wait_idle("fill_drain", 4000);
        check("fill_frames", 32'(frames_done - f0), 32'd4);

        // Drop enable mid-frame: the frame completes, the queued byte waits.
        f0 = frames_done;
        put_byte(8'h5A);
        put_byte(8'hC3);
        end_wr();
        wait_frame("en_start", 50);
        bus.i_tx_en = 1'b0;
        repeat (900) @(negedge clk);
        check("en_low_frames", 32'(frames_done - f0), 32'd1);
        check("en_low_busy", 32'(bus.o_busy), 32'd0);
        check_status("en_low");
        bus.i_tx_en = 1'b1;
        wait_idle("en_resume", 1500);
        check("en_frames", 32'(frames_done - f0), 32'd2);

        // 256 random bytes with random tick spacing, random write timing and brief enable drops.
        tick_mode = 2;
        f0 = frames_done;
        sent = 0;
        guard = 0;
        while (sent < 256 && guard < 70000) begin
            @(negedge clk);
            guard++;
            bus.i_tx_en = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                bus.i_wr      = 1'b1;
                bus.i_tx_data = b;
                if (model_q.size() >= DEPTH) model_ovf = 1'b1;
                else begin
                    model_q.push_back(b);
                    sent++;
                end
            end else begin
                bus.i_wr = 1'b0;
            end
        end
        check("rand_sent", 32'(sent), 32'd256);
        end_wr();
        bus.i_tx_en = 1'b1;
        wait_idle("rand_idle", 2000);
        check("rand_frames", 32'(frames_done - f0), 32'd256);
        check_status("rand_end");

        // Reset in the middle of the data bits of 0x55 with another byte queued.
        tick_mode   = 1;
        bus.i_tx_en = 1'b1;
        f0 = frames_done;
        put_byte(8'h55);
        put_byte(8'h66);
        end_wr();
        wait_frame("rst_frame", 50);
        repeat (OS * 4 * 3) @(negedge clk);
        check("rst_pre_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        reset_checks("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (800) @(negedge clk);
        check("rst_no_done", 32'(frames_done - f0), 32'd0);
        check_status("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
